// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
package rr_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic int rr_next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority picker: first set request at or after ptr, wrapping modulo N.
module rr_priority_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        // Walk from the farthest offset down so the closest hit to ptr wins.
        for (int off = N - 1; off >= 0; off--) begin
            j = int'(ptr) + off;
            if (j >= N) begin
                j = j - N;
            end
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_stream_arbiter.sv
// Packet-locking round-robin merge of NUM_REQ valid/ready streams onto one
// registered output stage tagged with the source index.
module rr_stream_arbiter
    import rr_arb_pkg::*;
#(
    parameter int  NUM_REQ    = 4,
    parameter int  DATA_WIDTH = 32,
    localparam int SRC_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_last,
    output logic [SRC_W-1:0]              out_src,
    output logic                          busy
);

    arb_state_e            state_q, state_d;
    logic [SRC_W-1:0]      ptr_q, ptr_d;
    logic [SRC_W-1:0]      owner_q, owner_d;
    logic [SRC_W-1:0]      pick_idx, sel;
    logic [NUM_REQ-1:0]    pick_grant, sel_oh;
    logic                  pick_any, sel_vld, sel_last;
    logic                  can_load, accept;
    logic [DATA_WIDTH-1:0] sel_data;

    rr_priority_pick #(
        .N     (NUM_REQ),
        .IDX_W (SRC_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        sel     = pick_idx;
        sel_oh  = pick_grant;
        sel_vld = pick_any;
        if (state_q == ARB_LOCKED) begin
            sel             = owner_q;
            sel_oh          = '0;
            sel_oh[owner_q] = 1'b1;
            sel_vld         = req_valid[owner_q];
        end
    end

    assign sel_last = req_last[sel];
    assign sel_data = req_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];

    // rst_n gates the handshake so nothing is granted while reset is asserted.
    assign can_load  = !out_valid || out_ready;
    assign accept    = rst_n && can_load && sel_vld;
    assign req_ready = accept ? sel_oh : '0;
    assign busy      = (state_q == ARB_LOCKED) || out_valid;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        if (accept) begin
            if (sel_last) begin
                state_d = ARB_IDLE;
                ptr_d   = SRC_W'(rr_next_idx(int'(sel), NUM_REQ));
            end else begin
                state_d = ARB_LOCKED;
                owner_d = sel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_last  <= sel_last;
                out_src   <= sel;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed bench for rr_stream_arbiter (4 requesters, 32-bit data).
module tb_rr_stream_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_data;
    logic [3:0]   req_last;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic [1:0]   out_src;
    logic         busy;

    int passed = 0;
    int total  = 0;

    rr_stream_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_last  (req_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [31:0] d, input logic l);
        req_valid[i]         = v;
        req_data[i*32 +: 32] = d;
        req_last[i]          = l;
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;

        // Reset with all requesters valid
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 32'hA0 + i, 1'b1);
        tick();
        tick();
        chk("rst_req_ready", req_ready, 4'b0000);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_src", out_src, 2'd0);
        rst_n = 1'b1;
        settle();
        chk("rel_req_ready", req_ready, 4'b0001);
        chk("rel_out_valid", out_valid, 1'b0);

        // Round-robin single beats, one per cycle
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_valid", out_valid, 1'b1);
            chk("rr_src", out_src, k % 4);
            chk("rr_data", out_data, 32'hA0 + (k % 4));
            chk("rr_ready", req_ready, 4'b0001 << ((k + 1) % 4));
        end
        req_valid = '0;
        settle();
        chk("rr_idle_ready", req_ready, 4'b0000);
        tick();
        chk("rr_drain_valid", out_valid, 1'b0);
        chk("rr_drain_busy", busy, 1'b0);

        // Packet lock: req1 three beats, req2 waits (ptr = 0)
        set_req(1, 1'b1, 32'h10, 1'b0);
        set_req(2, 1'b1, 32'h20, 1'b1);
        settle();
        chk("lock_ready0", req_ready, 4'b0010);
        tick();
        set_req(1, 1'b1, 32'h11, 1'b0);
        settle();
        chk("lock_data0", out_data, 32'h10);
        chk("lock_src0", out_src, 2'd1);
        chk("lock_busy", busy, 1'b1);
        chk("lock_ready1", req_ready, 4'b0010);
        tick();
        set_req(1, 1'b1, 32'h12, 1'b1);
        settle();
        chk("lock_data1", out_data, 32'h11);
        chk("lock_last1", out_last, 1'b0);
        chk("lock_ready2", req_ready, 4'b0010);
        tick();
        set_req(1, 1'b0, 32'h0, 1'b0);
        settle();
        chk("lock_data2", out_data, 32'h12);
        chk("lock_last2", out_last, 1'b1);
        chk("lock_ready3", req_ready, 4'b0100);
        tick();
        set_req(2, 1'b0, 32'h0, 1'b0);
        settle();
        chk("lock_data3", out_data, 32'h20);
        chk("lock_src3", out_src, 2'd2);
        chk("lock_ready4", req_ready, 4'b0000);
        tick();
        chk("lock_drain", out_valid, 1'b0);

        // Backpressure (ptr = 3): 0x55 from req0 held for 5 cycles
        set_req(0, 1'b1, 32'h55, 1'b1);
        settle();
        chk("bp_ready0", req_ready, 4'b0001);
        tick();
        out_ready = 1'b0;
        set_req(0, 1'b1, 32'h56, 1'b1);
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("bp_hold_data", out_data, 32'h55);
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_ready", req_ready, 4'b0000);
            tick();
        end
        out_ready = 1'b1;
        settle();
        chk("bp_rel_ready", req_ready, 4'b0001);
        chk("bp_rel_data", out_data, 32'h55);
        tick();
        set_req(0, 1'b0, 32'h0, 1'b0);
        settle();
        chk("bp_next_data", out_data, 32'h56);
        chk("bp_next_valid", out_valid, 1'b1);
        tick();
        chk("bp_drain", out_valid, 1'b0);

        // Pointer wrap (ptr = 1): req3 packet, then req0 before req3 again
        set_req(3, 1'b1, 32'h30, 1'b0);
        settle();
        chk("wrap_ready0", req_ready, 4'b1000);
        tick();
        set_req(3, 1'b1, 32'h31, 1'b1);
        set_req(0, 1'b1, 32'h40, 1'b1);
        settle();
        chk("wrap_locked_ready", req_ready, 4'b1000);
        tick();
        set_req(3, 1'b1, 32'h32, 1'b1);
        settle();
        chk("wrap_data1", out_data, 32'h31);
        chk("wrap_ready_after", req_ready, 4'b0001);
        tick();
        set_req(0, 1'b0, 32'h0, 1'b0);
        settle();
        chk("wrap_src_first", out_src, 2'd0);
        chk("wrap_data_first", out_data, 32'h40);
        chk("wrap_ready_next", req_ready, 4'b1000);
        tick();
        set_req(3, 1'b0, 32'h0, 1'b0);
        settle();
        chk("wrap_src_second", out_src, 2'd3);
        chk("wrap_data_second", out_data, 32'h32);
        tick();
        chk("wrap_drain", out_valid, 1'b0);

        // Reset mid-packet (ptr = 0)
        set_req(0, 1'b1, 32'h70, 1'b0);
        settle();
        chk("mid_ready0", req_ready, 4'b0001);
        tick();
        set_req(0, 1'b1, 32'h71, 1'b0);
        tick();
        set_req(0, 1'b1, 32'h72, 1'b0);
        settle();
        chk("mid_data", out_data, 32'h71);
        chk("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        set_req(0, 1'b0, 32'h0, 1'b0);
        set_req(2, 1'b1, 32'h90, 1'b1);
        settle();
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_data", out_data, 32'h0);
        chk("mid_rst_last", out_last, 1'b0);
        chk("mid_rst_src", out_src, 2'd0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ready", req_ready, 4'b0000);
        tick();
        rst_n = 1'b1;
        settle();
        chk("mid_rel_ready", req_ready, 4'b0100);
        tick();
        set_req(2, 1'b0, 32'h0, 1'b0);
        settle();
        chk("mid_out_valid", out_valid, 1'b1);
        chk("mid_out_src", out_src, 2'd2);
        chk("mid_out_data", out_data, 32'h90);
        chk("mid_out_last", out_last, 1'b1);
        chk("mid_not_locked", busy, 1'b1);
        tick();
        chk("mid_drain_busy", busy, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rr_stream_arbiter.md
# rr_stream_arbiter

Round-robin arbiter that shares one registered valid/ready output stage between `NUM_REQ` streaming requesters. Requesters send packets: a sequence of beats whose final beat carries `req_last`. The arbiter locks to one requester from that packet's first accepted beat until its last accepted beat, so packets never interleave. It sits in front of downstream pipeline stages as the single point where multiple producers merge onto one valid/ready channel, and it tags each output beat with its source index.

## Interface
- `NUM_REQ`, 4, number of requesters; minimum 1; need not be a power of two.
- `DATA_WIDTH`, 32, payload width per beat.
- `SRC_W`, `$clog2(NUM_REQ)` (1 when `NUM_REQ`=1), width of `out_src`; derived, never overridden.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  `NUM_REQ`  per-requester beat valid.
- `req_ready`  out  `NUM_REQ`  per-requester accept; at most one bit high in any cycle.
- `req_data`  in  `NUM_REQ*DATA_WIDTH`  flattened payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last`  in  `NUM_REQ`  per-requester end-of-packet flag, qualified by `req_valid`.
- `out_valid`  out  1  output beat valid (registered).
- `out_ready`  in  1  downstream accept.
- `out_data`  out  `DATA_WIDTH`  output payload (registered).
- `out_last`  out  1  end-of-packet flag of the output beat (registered).
- `out_src`  out  `SRC_W`  index of the requester that sourced the output beat (registered).
- `busy`  out  1  high when a packet is locked or `out_valid` is high.

## Operation
- **States.** `ARB_IDLE` (no owner) and `ARB_LOCKED` (owner register valid). Round-robin pointer `ptr` has range 0..`NUM_REQ`-1.
- **Select.**
  - In `ARB_IDLE`, `sel` is the first index with `req_valid` set, searching `ptr`, `ptr`+1, … modulo `NUM_REQ`.
  - In `ARB_LOCKED`, `sel` is the owner.
  - `sel_vld` means `req_valid[sel]`.
- **Ready.** `can_load` = !`out_valid` || `out_ready`. `req_ready[i]` = `can_load` && `sel_vld` && (i == `sel`). All `req_ready` bits are 0 while `rst_n` is low.
- **Accept.** A beat is accepted when `req_valid[sel]` && `req_ready[sel]`. On accept, the output register loads `req_data[sel]`, `req_last[sel]`, and `sel`, and `out_valid` is set to 1.
  - Accepted beat has `req_last`=1: next state is `ARB_IDLE`, and `ptr` becomes (`sel`+1) mod `NUM_REQ`.
  - Accepted beat has `req_last`=0: next state is `ARB_LOCKED`, and owner becomes `sel`.
- **No accept.** If `out_ready` is high, `out_valid` clears. Otherwise the output register holds its value.
- **Single-beat packets** (`req_last`=1 on the first beat) never enter `ARB_LOCKED`.
- **Owner stall.** In `ARB_LOCKED`, if the owner drops `req_valid`, the lock is kept and other requesters are not served. There is no timeout.
- **Requester obligation.** A requester keeps `req_valid`, `req_data`, and `req_last` stable until accepted.
- **`NUM_REQ`=1.** The block degenerates to a pipeline register plus the lock state; `out_src` is constant 0.

## Timing
- **Reset values.** `out_valid`=0, `out_data`=0, `out_last`=0, `out_src`=0, `busy`=0, state `ARB_IDLE`, `ptr`=0, owner=0.
- **Latency.** A beat accepted at edge N appears on the outputs after edge N.
- **Throughput.** One beat per cycle with `out_ready` held high, including across packet boundaries and changes of owner. There is no idle cycle between packets.
- **Combinational paths.** `out_ready` → `req_ready` and `req_valid` → `req_ready`. There is no path from inputs to `out_*`.
- **Simultaneous events.**
  - Output consumed and new beat accepted on the same edge: the register reloads and `out_valid` stays 1.
  - Last beat accepted and another requester valid on the same edge: the new requester is selected in the next cycle using the updated `ptr`.
- **Reset mid-packet.** The partial packet is discarded and the lock is released. Any held output beat is dropped. Arbitration restarts from index 0.

## Structure
- **Package `rr_arb_pkg`** holds:
  - `arb_state_e` (`ARB_IDLE`, `ARB_LOCKED`);
  - a function `rr_next_idx` implementing (idx+1) mod n.
- **Sub-module `rr_priority_pick`**: combinational. Inputs are the request vector and `ptr`; outputs are the one-hot grant, the binary index, and `any`. It is instantiated once.
- **Top level** contains the state register, `ptr`, owner, the output register, and the ready logic.

## Test plan
- **Reset.** Hold `rst_n` low for 2 cycles with all `req_valid`=1. Required: all `req_ready`=0, `out_valid`=0, `busy`=0. After release, `req_ready`=0001 on the first cycle.
- **Round-robin single beats.**
  - Stimulus: all 4 requesters valid with `req_last`=1; data 0xA0–0xA3 for requesters 0–3, each re-presenting after accept; `out_ready`=1.
  - Required: `out_src` sequence 0,1,2,3,0,… on consecutive cycles. First `out_valid` appears one cycle after the first accept.
- **Packet lock.**
  - Stimulus: requester 1 sends 0x10, 0x11, 0x12 (`last` on 0x12); requester 2 valid throughout with 0x20, `last`=1.
  - Required: output order 0x10, 0x11, 0x12, 0x20. `req_ready[2]`=0 until 0x12 is accepted.
- **Backpressure.**
  - Stimulus: with `out_valid`=1 holding 0x55, drive `out_ready`=0 for 5 cycles.
  - Required: `out_data` stays 0x55 and all `req_ready`=0. After release, subsequent beats arrive with no loss or duplication.
- **Pointer wrap.** After a packet from requester 3 completes, requesters 0 and 3 are both valid. Required: requester 0 is granted first, then requester 3.
- **Reset mid-packet.**
  - Stimulus: requester 0 has 2 of 4 beats accepted; then pulse `rst_n` low; then only requester 2 is valid.
  - Required: outputs return to reset values. Requester 2 is granted in the first cycle after release, and `out_src`=2.
